regfile_8x16: RTL and testbench

Eight-entry, 16-bit general-purpose register file for the 16-bit RISC CPU. It sits directly downstream of `dec_3to8`: the decoder's one-hot output drives this block's write select, and the write-back stage supplies the data. The block adds three things to the register storage. Reads are registered (synchronous). A per-register busy scoreboard raises a read stall on RAW hazards. A sticky error flag catches malformed write selects.

---
 rtl/regfile_8x16.sv | 94 +++++++++
 tb/tb_regfile_8x16.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_8x16.sv
// Eight-entry register file with registered reads, RAW busy scoreboard and a sticky bad-select flag.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_8x16 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        we_onehot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [2:0]        issue_addr,
    input  logic              rd_en,
    input  logic [2:0]        ra_addr,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              stall,
    output logic [7:0]        busy,
    input  logic              err_clr,
    output logic              we_err
);

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] ra_q, ra_d;
    logic [DATA_W-1:0] rb_q, rb_d;
    logic [7:0]        busy_q, busy_d;
    logic              err_q, err_d;
    logic              sel_onehot;
    logic              wr_valid;
    logic [7:0]        wr_sel;
    logic [7:0]        pend;
    logic              rd_go;

    // A select is valid only with exactly one bit set.
    assign sel_onehot = (we_onehot != 8'd0) && ((we_onehot & (we_onehot - 8'd1)) == 8'd0);
    assign wr_valid   = wr_en && sel_onehot;
    assign wr_sel     = wr_valid ? we_onehot : 8'd0;

    always_comb begin
        pend = busy_q;
`ifdef REGFILE_BYPASS_EN
        pend = busy_q & ~wr_sel;
`endif
        stall = rd_en && (pend[ra_addr] || pend[rb_addr]);
        rd_go = rd_en && !stall;
    end

    always_comb begin
        ra_d = ra_q;
        rb_d = rb_q;
        if (rd_go) begin
            ra_d = regs_q[ra_addr];
            rb_d = regs_q[rb_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_sel[ra_addr]) ra_d = wr_data;
            if (wr_sel[rb_addr]) rb_d = wr_data;
`endif
        end
    end

    // Write-back clears first, then a new issue sets, so a same-cycle issue keeps the bit high.
    always_comb begin
        busy_d = busy_q & ~wr_sel;
        if (issue_en) busy_d = busy_d | (8'd1 << issue_addr);
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (wr_en && !sel_onehot) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            busy_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) regs_q[i] <= wr_data;
            end
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign ra_data = ra_q;
    assign rb_data = rb_q;
    assign busy    = busy_q;
    assign we_err  = err_q;

endmodule

// File: tb/tb_regfile_8x16.sv
// Self-checking bench for regfile_8x16: directed cases plus randomized traffic against an array model.
module tb_regfile_8x16;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  we_onehot;
    logic [15:0] wr_data;
    logic        issue_en;
    logic [2:0]  issue_addr;
    logic        rd_en;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        stall;
    logic [7:0]  busy;
    logic        err_clr;
    logic        we_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_mem [8];
    logic [7:0]  m_busy;
    logic        m_err;
    logic [15:0] m_ra;
    logic [15:0] m_rb;

    regfile_8x16 #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .we_onehot(we_onehot), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .rd_en(rd_en), .ra_addr(ra_addr),
        .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data), .stall(stall), .busy(busy),
        .err_clr(err_clr), .we_err(we_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sel_index(input logic [7:0] sel);
        for (int i = 0; i < 8; i++) if (sel == (8'd1 << i)) return i;
        return -1;
    endfunction

    function automatic logic model_stall();
        int idx;
        logic [7:0] p;
        p = m_busy;
        idx = wr_en ? sel_index(we_onehot) : -1;
`ifdef REGFILE_BYPASS_EN
        if (idx >= 0) p[idx] = 1'b0;
`endif
        return rd_en && (p[ra_addr] || p[rb_addr]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_busy = 8'h0;
        m_err  = 1'b0;
        m_ra   = 16'h0;
        m_rb   = 16'h0;
    endtask

    task automatic model_edge(input logic st);
        int idx;
        idx = wr_en ? sel_index(we_onehot) : -1;
        if (rd_en && !st) begin
            m_ra = m_mem[ra_addr];
            m_rb = m_mem[rb_addr];
`ifdef REGFILE_BYPASS_EN
            if (idx == int'(ra_addr)) m_ra = wr_data;
            if (idx == int'(rb_addr)) m_rb = wr_data;
`endif
        end
        if (err_clr) m_err = 1'b0;
        if (idx >= 0) begin
            m_mem[idx] = wr_data;
            m_busy[idx] = 1'b0;
        end else if (wr_en) begin
            m_err = 1'b1;
        end
        if (issue_en) m_busy[issue_addr] = 1'b1;
    endtask

    task automatic idle();
        wr_en = 0; we_onehot = 8'h0; wr_data = 16'h0; issue_en = 0; issue_addr = 3'd0;
        rd_en = 0; ra_addr = 3'd0; rb_addr = 3'd0; err_clr = 0;
    endtask

    // Inputs are already driven; check stall before the edge, outputs after it.
    task automatic cycle();
        logic exp_st;
        #1;
        exp_st = model_stall();
        chk("stall", {31'b0, stall}, {31'b0, exp_st});
        @(posedge clk);
        model_edge(exp_st);
        #1;
        chk("ra_data", {16'b0, ra_data}, {16'b0, m_ra});
        chk("rb_data", {16'b0, rb_data}, {16'b0, m_rb});
        chk("busy", {24'b0, busy}, {24'b0, m_busy});
        chk("we_err", {31'b0, we_err}, {31'b0, m_err});
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_ra", {16'b0, ra_data}, 32'h0);
        chk("rst_rb", {16'b0, rb_data}, 32'h0);
        chk("rst_busy", {24'b0, busy}, 32'h0);
        chk("rst_err", {31'b0, we_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write then read
        wr_en = 1; we_onehot = 8'h08; wr_data = 16'hBEEF;
        cycle();
        idle(); rd_en = 1; ra_addr = 3'd3; rb_addr = 3'd0;
        cycle();
        chk("t1_ra", {16'b0, ra_data}, 32'hBEEF);
        chk("t1_rb", {16'b0, rb_data}, 32'h0);

        // Malformed selects
        idle(); wr_en = 1; we_onehot = 8'h00; wr_data = 16'hDEAD;
        cycle();
        chk("t2_err_zero", {31'b0, we_err}, 32'h1);
        we_onehot = 8'h11;
        cycle();
        chk("t2_err_multi", {31'b0, we_err}, 32'h1);
        idle();
        cycle();
        chk("t2_err_held", {31'b0, we_err}, 32'h1);
        err_clr = 1;
        cycle();
        chk("t2_err_clr", {31'b0, we_err}, 32'h0);
        idle(); rd_en = 1; ra_addr = 3'd0; rb_addr = 3'd4;
        cycle();
        chk("t2_r0", {16'b0, ra_data}, 32'h0);
        chk("t2_r4", {16'b0, rb_data}, 32'h0);

        // Scoreboard stall on r5
        idle(); issue_en = 1; issue_addr = 3'd5;
        cycle();
        idle(); rd_en = 1; ra_addr = 3'd5; rb_addr = 3'd5;
        #1;
        chk("t3_stall", {31'b0, stall}, 32'h1);
        cycle();
        chk("t3_hold", {16'b0, ra_data}, 32'h0);
        wr_en = 1; we_onehot = 8'h20; wr_data = 16'h1234;
        cycle();
        chk("t3_busy5", {31'b0, busy[5]}, 32'h0);
        idle(); rd_en = 1; ra_addr = 3'd5; rb_addr = 3'd3;
        cycle();
        chk("t3_ra", {16'b0, ra_data}, 32'h1234);

        // Same-cycle write and read of r2
        idle(); wr_en = 1; we_onehot = 8'h04; wr_data = 16'h1111;
        cycle();
        wr_data = 16'hA5A5; rd_en = 1; ra_addr = 3'd2; rb_addr = 3'd2;
        cycle();
`ifdef REGFILE_BYPASS_EN
        chk("t4_ra", {16'b0, ra_data}, 32'hA5A5);
`else
        chk("t4_ra", {16'b0, ra_data}, 32'h1111);
`endif

        // Issue and write-back on r7 together
        idle(); wr_en = 1; we_onehot = 8'h80; wr_data = 16'h7777; issue_en = 1; issue_addr = 3'd7;
        cycle();
        chk("t5_busy7", {31'b0, busy[7]}, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            idle();
            wr_en      = ($urandom % 2) == 0;
            we_onehot  = (($urandom % 8) == 0) ? 8'($urandom % 256) : (8'd1 << ($urandom % 8));
            wr_data    = 16'($urandom);
            issue_en   = ($urandom % 4) == 0;
            issue_addr = 3'($urandom);
            rd_en      = ($urandom % 2) == 0;
            ra_addr    = 3'($urandom);
            rb_addr    = 3'($urandom);
            err_clr    = ($urandom % 8) == 0;
            cycle();
        end

        // Fill registers with nonzero data, read one, then make every register busy
        for (int i = 0; i < 8; i++) begin
            idle(); wr_en = 1; we_onehot = 8'd1 << i; wr_data = 16'h1000 + 16'(i);
            cycle();
        end
        idle(); rd_en = 1; ra_addr = 3'd6; rb_addr = 3'd1;
        cycle();
        chk("t6_pre_ra", {16'b0, ra_data}, 32'h1006);
        for (int i = 0; i < 8; i++) begin
            idle(); issue_en = 1; issue_addr = 3'(i);
            cycle();
        end
        chk("t6_pre_busy", {24'b0, busy}, 32'hFF);

        // Reset mid-cycle with activity on the inputs
        wr_en = 1; we_onehot = 8'h00; rd_en = 1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_ra", {16'b0, ra_data}, 32'h0);
        chk("t6_rb", {16'b0, rb_data}, 32'h0);
        chk("t6_busy", {24'b0, busy}, 32'h0);
        chk("t6_err", {31'b0, we_err}, 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1; ra_addr = 3'd6; rb_addr = 3'd1;
        cycle();
        chk("t6_post_r6", {16'b0, ra_data}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
